// File: rtl/spi_flash_read_cache.sv
// Direct-mapped, read-only word cache in front of the mapped SPI flash word reader.
// Define SPI_FLASH_CACHE_STATS_EN to add the saturating hit_count/miss_count ports.
module spi_flash_read_cache #(
    parameter int LINES       = 16,
    parameter int REQ_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rstrb,
    input  logic [19:0] cpu_word_addr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rbusy,
    output logic        cpu_err,
    input  logic        flush,
    output logic        flash_rstrb,
    output logic [19:0] flash_word_address,
    input  logic [31:0] flash_rdata,
    input  logic        flash_rbusy
`ifdef SPI_FLASH_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 20 - IDX_W;
    localparam int CNT_W = $clog2(REQ_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rbusy_q, rbusy_d;
    logic               err_q, err_d;
    logic               frstrb_q, frstrb_d;
    logic [19:0]        faddr_q, faddr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fill_ok_q, fill_ok_d;
    logic [LINES-1:0]   valid_q;
    logic [31:0]        data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];

    logic [IDX_W-1:0]   lk_idx, fill_idx;
    logic               hit, fill, lookup_hit, lookup_miss;

    assign lk_idx   = cpu_word_addr[IDX_W-1:0];
    assign fill_idx = faddr_q[IDX_W-1:0];
    // A flush in the same cycle as a lookup forces a miss.
    assign hit = valid_q[lk_idx] && (tag_mem[lk_idx] == cpu_word_addr[19:IDX_W]) && !flush;
    assign lookup_hit  = (state_q == S_IDLE) && cpu_rstrb && hit;
    assign lookup_miss = (state_q == S_IDLE) && cpu_rstrb && !hit;

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        rbusy_d   = rbusy_q;
        err_d     = 1'b0;
        frstrb_d  = frstrb_q;
        faddr_d   = faddr_q;
        cnt_d     = cnt_q;
        fill_ok_d = fill_ok_q;
        fill      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lookup_hit) begin
                    rdata_d = data_mem[lk_idx];
                end else if (lookup_miss) begin
                    faddr_d   = cpu_word_addr;
                    frstrb_d  = 1'b1;
                    rbusy_d   = 1'b1;
                    cnt_d     = '0;
                    fill_ok_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) fill_ok_d = 1'b0;
                if (flash_rbusy) begin
                    frstrb_d = 1'b0;
                    state_d  = S_WAIT;
                end else if (cnt_q == CNT_W'(REQ_TIMEOUT - 1)) begin
                    frstrb_d = 1'b0;
                    rdata_d  = 32'hFFFF_FFFF;
                    err_d    = 1'b1;
                    rbusy_d  = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (flush) fill_ok_d = 1'b0;
                if (!flash_rbusy) begin
                    fill    = 1'b1;
                    rdata_d = flash_rdata;
                    rbusy_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rdata_q   <= '0;
            rbusy_q   <= 1'b0;
            err_q     <= 1'b0;
            frstrb_q  <= 1'b0;
            faddr_q   <= '0;
            cnt_q     <= '0;
            fill_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            rbusy_q   <= rbusy_d;
            err_q     <= err_d;
            frstrb_q  <= frstrb_d;
            faddr_q   <= faddr_d;
            cnt_q     <= cnt_d;
            fill_ok_q <= fill_ok_d;
        end
    end

    // A fill that raced with a flush still updates storage but stays invalid.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
        end else if (fill && fill_ok_q) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill && !reset) begin
            data_mem[fill_idx] <= flash_rdata;
            tag_mem[fill_idx]  <= faddr_q[19:IDX_W];
        end
    end

`ifdef SPI_FLASH_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (lookup_hit && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (lookup_miss && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    assign cpu_rdata          = rdata_q;
    assign cpu_rbusy          = rbusy_q;
    assign cpu_err            = err_q;
    assign flash_rstrb        = frstrb_q;
    assign flash_word_address = faddr_q;
endmodule

// File: tb/tb_spi_flash_read_cache.sv
// Randomized self-checking bench for spi_flash_read_cache with a behavioural flash reader
// and an address-level cache model (LINES=16, REQ_TIMEOUT=15).
module tb_spi_flash_read_cache;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_rstrb = 1'b0;
    logic [19:0] cpu_word_addr = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_rbusy;
    logic        cpu_err;
    logic        flush = 1'b0;
    logic        flash_rstrb;
    logic [19:0] flash_word_address;
    logic [31:0] flash_rdata;
    logic        flash_rbusy;
`ifdef SPI_FLASH_CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int tests = 0;
    int fails = 0;

    spi_flash_read_cache #(.LINES(16), .REQ_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .cpu_rstrb(cpu_rstrb), .cpu_word_addr(cpu_word_addr),
        .cpu_rdata(cpu_rdata), .cpu_rbusy(cpu_rbusy), .cpu_err(cpu_err), .flush(flush),
        .flash_rstrb(flash_rstrb), .flash_word_address(flash_word_address),
        .flash_rdata(flash_rdata), .flash_rbusy(flash_rbusy)
`ifdef SPI_FLASH_CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Flash contents: a fixed word at 0x10, an address-derived pattern elsewhere.
    function automatic logic [31:0] fdata(input logic [19:0] a);
        if (a == 20'h00010) return 32'hDEAD_BEEF;
        return {a[11:0], a} ^ 32'h5A5A_C3C3;
    endfunction

    // Behavioural flash reader
    int   ack_delay = 0;
    int   busy_cycles = 4;
    logic flash_never = 1'b0;
    logic [19:0] fm_addr;
    initial begin
        flash_rbusy = 1'b0;
        flash_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset && flash_rstrb === 1'b1 && !flash_never) begin
                fm_addr = flash_word_address;
                for (int i = 0; i < ack_delay && !reset; i++) begin @(posedge clk); #1; end
                if (!reset) begin
                    flash_rbusy = 1'b1;
                    for (int i = 0; i < busy_cycles && !reset; i++) begin @(posedge clk); #1; end
                    if (!reset) flash_rdata = fdata(fm_addr);
                    flash_rbusy = 1'b0;
                end
            end
        end
    end

    int   strobe_cnt = 0;
    logic prev_rstrb = 1'b0;
    initial forever begin
        @(negedge clk);
        if (flash_rstrb === 1'b1 && prev_rstrb !== 1'b1) strobe_cnt++;
        prev_rstrb = flash_rstrb;
    end

    // Cache model: which full word address each line currently holds.
    logic [19:0] ref_addr [16];
    bit          ref_ok   [16];

    task automatic model_clear();
        for (int i = 0; i < 16; i++) ref_ok[i] = 1'b0;
    endtask

    function automatic bit model_hit(input logic [19:0] a);
        return ref_ok[a % 16] && ref_addr[a % 16] == a;
    endfunction

    task automatic model_fill(input logic [19:0] a);
        ref_addr[a % 16] = a;
        ref_ok[a % 16]   = 1'b1;
    endtask

    task automatic do_flush();
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
    endtask

    task automatic do_read(input logic [19:0] a, input logic fl,
                           output logic [31:0] d, output logic miss, output logic ok);
        int n;
        @(posedge clk); #1; cpu_rstrb = 1'b1; cpu_word_addr = a; flush = fl;
        @(posedge clk); #1; cpu_rstrb = 1'b0; flush = 1'b0;
        miss = cpu_rbusy;
        n = 0;
        while (cpu_rbusy === 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
        ok = (cpu_rbusy === 1'b0);
        d  = cpu_rdata;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (cpu_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", cpu_rdata); end
        tests++; if (cpu_rbusy !== 1'b0) begin fails++; $display("FAIL reset_rbusy got %b want 0", cpu_rbusy); end
        tests++; if (cpu_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", cpu_err); end
        tests++; if (flash_rstrb !== 1'b0) begin fails++; $display("FAIL reset_frstrb got %b want 0", flash_rstrb); end
        tests++; if (flash_word_address !== 20'h0) begin fails++; $display("FAIL reset_faddr got %h want 0", flash_word_address); end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_cold_miss();
        logic [31:0] d; logic miss, ok; int s0;
        ack_delay = 0; busy_cycles = 80; s0 = strobe_cnt;
        do_read(20'h00010, 1'b0, d, miss, ok);
        tests++; if (miss !== 1'b1) begin fails++; $display("FAIL cold_miss_busy got %b want 1", miss); end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL cold_miss_done got %b want 1", ok); end
        tests++; if (d !== 32'hDEAD_BEEF) begin fails++; $display("FAIL cold_miss_data got %h want deadbeef", d); end
        tests++; if (strobe_cnt - s0 != 1) begin fails++; $display("FAIL cold_miss_strobes got %0d want 1", strobe_cnt - s0); end
        tests++; if (flash_word_address !== 20'h00010) begin fails++; $display("FAIL cold_miss_faddr got %h want 00010", flash_word_address); end
        model_fill(20'h00010);
    endtask

    task automatic test_hit();
        logic [31:0] d; logic miss, ok; int s0;
        s0 = strobe_cnt;
        do_read(20'h00010, 1'b0, d, miss, ok);
        tests++; if (miss !== 1'b0) begin fails++; $display("FAIL hit_busy got %b want 0", miss); end
        tests++; if (d !== 32'hDEAD_BEEF) begin fails++; $display("FAIL hit_data got %h want deadbeef", d); end
        tests++; if (strobe_cnt != s0) begin fails++; $display("FAIL hit_strobes got %0d want 0", strobe_cnt - s0); end
    endtask

    task automatic test_conflict();
        logic [19:0] seq [3];
        logic [31:0] d; logic miss, ok; int s0;
        seq[0] = 20'h00010; seq[1] = 20'h00020; seq[2] = 20'h00010;
        busy_cycles = 5;
        do_flush(); model_clear();
        s0 = strobe_cnt;
        for (int i = 0; i < 3; i++) begin
            do_read(seq[i], 1'b0, d, miss, ok);
            tests++; if (miss !== 1'b1 || !ok) begin fails++; $display("FAIL conflict_miss[%0d] got %b want 1", i, miss); end
            tests++; if (d !== fdata(seq[i])) begin fails++; $display("FAIL conflict_data[%0d] got %h want %h", i, d, fdata(seq[i])); end
            model_fill(seq[i]);
        end
        tests++; if (strobe_cnt - s0 != 3) begin fails++; $display("FAIL conflict_strobes got %0d want 3", strobe_cnt - s0); end
    endtask

    task automatic test_flush_wait();
        logic [31:0] d; logic miss, ok; int n;
        busy_cycles = 20;
        @(posedge clk); #1; cpu_rstrb = 1'b1; cpu_word_addr = 20'h00030;
        @(posedge clk); #1; cpu_rstrb = 1'b0;
        n = 0;
        while (flash_rbusy !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        n = 0;
        while (cpu_rbusy === 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
        tests++; if (cpu_rbusy !== 1'b0 || cpu_rdata !== fdata(20'h00030)) begin
            fails++; $display("FAIL flush_wait_data got %h want %h", cpu_rdata, fdata(20'h00030)); end
        model_clear();
        busy_cycles = 3;
        do_read(20'h00030, 1'b0, d, miss, ok);
        tests++; if (miss !== 1'b1) begin fails++; $display("FAIL flush_wait_refill got %b want 1", miss); end
        tests++; if (d !== fdata(20'h00030)) begin fails++; $display("FAIL flush_wait_refill_data got %h want %h", d, fdata(20'h00030)); end
        model_fill(20'h00030);
    endtask

    task automatic test_random();
        logic [31:0] d; logic miss, ok, fl, exp_miss; logic [19:0] a; int r;
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 11);
            if (r == 0) begin
                do_flush(); model_clear();
            end else begin
                a = (r == 1) ? 20'hFFFFF : 20'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
                fl = ($urandom_range(0, 7) == 0);
                ack_delay = $urandom_range(0, 4);
                busy_cycles = $urandom_range(1, 8);
                if (fl) model_clear();
                exp_miss = !model_hit(a);
                do_read(a, fl, d, miss, ok);
                tests++; if (miss !== exp_miss || !ok) begin fails++; $display("FAIL rand_miss[%0d] addr %h got %b want %b", it, a, miss, exp_miss); end
                tests++; if (d !== fdata(a)) begin fails++; $display("FAIL rand_data[%0d] addr %h got %h want %h", it, a, d, fdata(a)); end
                model_fill(a);
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d, err_data; logic miss, ok; int strobe_cycles, err_cycles;
        do_flush(); model_clear();
        flash_never = 1'b1;
        strobe_cycles = 0; err_cycles = 0; err_data = '0;
        @(posedge clk); #1; cpu_rstrb = 1'b1; cpu_word_addr = 20'h00044;
        @(posedge clk); #1; cpu_rstrb = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (flash_rstrb === 1'b1) strobe_cycles++;
            if (cpu_err === 1'b1) begin err_cycles++; err_data = cpu_rdata; end
        end
        flash_never = 1'b0;
        tests++; if (strobe_cycles != 15) begin fails++; $display("FAIL timeout_strobe_cycles got %0d want 15", strobe_cycles); end
        tests++; if (err_cycles != 1) begin fails++; $display("FAIL timeout_err_pulse got %0d want 1", err_cycles); end
        tests++; if (err_data !== 32'hFFFF_FFFF) begin fails++; $display("FAIL timeout_rdata got %h want ffffffff", err_data); end
        tests++; if (cpu_rbusy !== 1'b0) begin fails++; $display("FAIL timeout_rbusy got %b want 0", cpu_rbusy); end
        busy_cycles = 3; ack_delay = 0;
        do_read(20'h00044, 1'b0, d, miss, ok);
        tests++; if (miss !== 1'b1) begin fails++; $display("FAIL timeout_nofill got %b want 1", miss); end
        tests++; if (d !== fdata(20'h00044)) begin fails++; $display("FAIL timeout_refill_data got %h want %h", d, fdata(20'h00044)); end
        model_fill(20'h00044);
    endtask

    task automatic test_reset_mid();
        int n;
        busy_cycles = 30; ack_delay = 0;
        @(posedge clk); #1; cpu_rstrb = 1'b1; cpu_word_addr = 20'h00055;
        @(posedge clk); #1; cpu_rstrb = 1'b0;
        n = 0;
        while (flash_rbusy !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        repeat (3) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1;
        tests++; if (flash_rstrb !== 1'b0) begin fails++; $display("FAIL reset_mid_frstrb got %b want 0", flash_rstrb); end
        tests++; if (cpu_rbusy !== 1'b0) begin fails++; $display("FAIL reset_mid_rbusy got %b want 0", cpu_rbusy); end
        tests++; if (cpu_rdata !== 32'h0) begin fails++; $display("FAIL reset_mid_rdata got %h want 0", cpu_rdata); end
`ifdef SPI_FLASH_CACHE_STATS_EN
        tests++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            fails++; $display("FAIL reset_mid_stats got hit %0d miss %0d want 0 0", hit_count, miss_count); end
`endif
        @(posedge clk); #1; reset = 1'b0;
        model_clear();
    endtask

`ifdef SPI_FLASH_CACHE_STATS_EN
    task automatic test_stats();
        logic [31:0] d; logic miss, ok;
        busy_cycles = 4;
        for (int i = 0; i < 4; i++) do_read(20'h00066, 1'b0, d, miss, ok);
        do_flush();
        tests++; if (miss_count !== 32'd1) begin fails++; $display("FAIL stats_miss got %0d want 1", miss_count); end
        tests++; if (hit_count !== 32'd3) begin fails++; $display("FAIL stats_hit got %0d want 3", hit_count); end
        model_clear();
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_wait();
        test_random();
        test_timeout();
        test_reset_mid();
`ifdef SPI_FLASH_CACHE_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
